// File: rtl/softmax_max_sub.sv
// Softmax pre-stage: buffers one row of Q2.13 scores, tracks the row maximum,
// then streams each score minus that maximum (saturating). Option: SOFTMAX_ROWMAX_OUT_EN.
module softmax_max_sub #(
    parameter int ROW_LEN = 16,
    parameter int DW      = 16
) (
    input  logic          I_CLK,
    input  logic          I_RST,
    input  logic          I_VALID,
    input  logic [DW-1:0] I_DATA,
    output logic          O_READY,
    output logic          O_VALID,
    output logic [DW-1:0] O_DATA,
    output logic          O_LAST,
`ifdef SOFTMAX_ROWMAX_OUT_EN
    input  logic          I_READY,
    output logic [DW-1:0] O_ROW_MAX
`else
    input  logic          I_READY
`endif
);

    localparam int            IW       = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(ROW_LEN - 1);
    localparam logic [DW-1:0] MIN_VAL  = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic {LOAD, DRAIN} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic [DW-1:0] max_q, max_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] mem_q [ROW_LEN];
    logic [DW-1:0] mem_d [ROW_LEN];

    logic in_hs;
    logic out_hs;

    // One extra bit of headroom; only the negative side can overflow in practice.
    function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] diff;
        diff = {a[DW-1], a} - {b[DW-1], b};
        if (diff[DW] != diff[DW-1])
            sat_sub = diff[DW] ? MIN_VAL : ~MIN_VAL;
        else
            sat_sub = diff[DW-1:0];
    endfunction

    // State register
    always_ff @(posedge I_CLK) begin
        if (I_RST)
            state_q <= LOAD;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (I_VALID && (wr_idx_q == LAST_IDX)) state_d = DRAIN;
            DRAIN:   if (I_READY && (rd_idx_q == LAST_IDX)) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // Output decode
    always_comb begin
        O_READY = (state_q == LOAD);
        O_VALID = (state_q == DRAIN);
        O_LAST  = (state_q == DRAIN) && (rd_idx_q == LAST_IDX);
        O_DATA  = data_q;
    end

`ifdef SOFTMAX_ROWMAX_OUT_EN
    assign O_ROW_MAX = max_q;
`endif

    assign in_hs  = O_READY & I_VALID;
    assign out_hs = O_VALID & I_READY;

    // Datapath
    always_comb begin
        mem_d    = mem_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        max_d    = max_q;
        data_d   = data_q;

        if (in_hs) begin
            mem_d[wr_idx_q] = I_DATA;
            if ((wr_idx_q == '0) || ($signed(I_DATA) > $signed(max_q)))
                max_d = I_DATA;
            // Element 0 is already buffered, so the first output is ready on entry to DRAIN.
            if (wr_idx_q == LAST_IDX) begin
                wr_idx_d = '0;
                data_d   = sat_sub(mem_q[0], max_d);
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end

        if (out_hs) begin
            if (rd_idx_q == LAST_IDX) begin
                rd_idx_d = '0;
            end else begin
                rd_idx_d = rd_idx_q + 1'b1;
                data_d   = sat_sub(mem_q[rd_idx_d], max_q);
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            max_q    <= MIN_VAL;
            data_q   <= '0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            max_q    <= max_d;
            data_q   <= data_d;
        end
    end

    // Row buffer is never cleared; stale entries are always overwritten before use.
    always_ff @(posedge I_CLK) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_softmax_max_sub.sv
// Directed self-checking bench for softmax_max_sub (ROW_LEN=16, DW=16).
module tb_softmax_max_sub;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [15:0] i_data;
    logic        o_ready;
    logic        o_valid;
    logic [15:0] o_data;
    logic        o_last;
    logic        i_ready;
`ifdef SOFTMAX_ROWMAX_OUT_EN
    logic [15:0] o_row_max;
`endif

    int total = 0;
    int bad   = 0;

    logic [15:0] row   [16];
    logic [15:0] exp_q [16];

    always #5 clk = ~clk;

    softmax_max_sub #(.ROW_LEN(16), .DW(16)) dut (
        .I_CLK    (clk),
        .I_RST    (rst),
        .I_VALID  (i_valid),
        .I_DATA   (i_data),
        .O_READY  (o_ready),
        .O_VALID  (o_valid),
        .O_DATA   (o_data),
        .O_LAST   (o_last),
`ifdef SOFTMAX_ROWMAX_OUT_EN
        .I_READY  (i_ready),
        .O_ROW_MAX(o_row_max)
`else
        .I_READY  (i_ready)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

`ifdef SOFTMAX_ROWMAX_OUT_EN
    function automatic logic [15:0] row_max();
        logic [15:0] m;
        m = row[0];
        for (int i = 1; i < 16; i++)
            if ($signed(row[i]) > $signed(m)) m = row[i];
        return m;
    endfunction
`endif

    // Called on a negedge; leaves on the negedge after the 16th accept.
    task automatic load_row(input string tag);
        for (int i = 0; i < 16; i++) begin
            i_valid = 1'b1;
            i_data  = row[i];
            chk({tag, ".ready"}, {31'd0, o_ready}, 32'd1);
            chk({tag, ".novalid"}, {31'd0, o_valid}, 32'd0);
            @(negedge clk);
        end
        i_valid = 1'b0;
        i_data  = '0;
    endtask

    task automatic drain_from(input string tag, input int start);
        i_ready = 1'b1;
        for (int i = start; i < 16; i++) begin
            chk({tag, ".valid"}, {31'd0, o_valid}, 32'd1);
            chk({tag, ".rdy0"}, {31'd0, o_ready}, 32'd0);
            chk($sformatf("%s.data[%0d]", tag, i), {16'd0, o_data}, {16'd0, exp_q[i]});
            chk($sformatf("%s.last[%0d]", tag, i), {31'd0, o_last}, (i == 15) ? 32'd1 : 32'd0);
`ifdef SOFTMAX_ROWMAX_OUT_EN
            chk({tag, ".rowmax"}, {16'd0, o_row_max}, {16'd0, row_max()});
`endif
            @(negedge clk);
        end
        chk({tag, ".end_valid"}, {31'd0, o_valid}, 32'd0);
        chk({tag, ".end_ready"}, {31'd0, o_ready}, 32'd1);
        chk({tag, ".end_last"}, {31'd0, o_last}, 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        repeat (2) @(negedge clk);
        chk("rst.valid", {31'd0, o_valid}, 32'd0);
        chk("rst.ready", {31'd0, o_ready}, 32'd1);
        chk("rst.last", {31'd0, o_last}, 32'd0);
        chk("rst.data", {16'd0, o_data}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Ascending row 0..15: outputs i-15
        for (int i = 0; i < 16; i++) begin
            row[i]   = 16'(i);
            exp_q[i] = 16'(i) - 16'd15;
        end
        load_row("asc");
        drain_from("asc", 0);

        // Extremes: saturation of 0x8000 - 0x7FFF, zeros give 0x8001
        for (int i = 0; i < 16; i++) begin
            row[i]   = 16'h0000;
            exp_q[i] = 16'h8001;
        end
        row[2] = 16'h7FFF;  exp_q[2] = 16'h0000;
        row[5] = 16'h8000;  exp_q[5] = 16'h8000;
        load_row("sat");
        drain_from("sat", 0);

        // All-negative ties; also proves the max reloads on the first score
        for (int i = 0; i < 16; i++) begin
            row[i]   = 16'hE000;
            exp_q[i] = 16'h0000;
        end
        load_row("neg");
        drain_from("neg", 0);

        // Backpressure at rd_idx=3 with I_VALID toggling during DRAIN
        for (int i = 0; i < 16; i++) begin
            row[i]   = 16'(i);
            exp_q[i] = 16'(i) - 16'd15;
        end
        load_row("bp");
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp.pre[%0d]", i), {16'd0, o_data}, {16'd0, exp_q[i]});
            @(negedge clk);
        end
        i_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i_valid = k[0] ? 1'b0 : 1'b1;
            i_data  = 16'h7FFF;
            chk("bp.hold_data", {16'd0, o_data}, {16'd0, exp_q[3]});
            chk("bp.hold_last", {31'd0, o_last}, 32'd0);
            chk("bp.hold_ready", {31'd0, o_ready}, 32'd0);
            chk("bp.hold_valid", {31'd0, o_valid}, 32'd1);
            @(negedge clk);
        end
        i_valid = 1'b0;
        i_data  = '0;
        drain_from("bp", 3);

        // Reset at rd_idx=7 discards the row
        for (int i = 0; i < 16; i++) begin
            row[i]   = 16'(2 * i);
            exp_q[i] = 16'(2 * i) - 16'd30;
        end
        load_row("rstd");
        i_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("rstd.pre[%0d]", i), {16'd0, o_data}, {16'd0, exp_q[i]});
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstd.valid", {31'd0, o_valid}, 32'd0);
        chk("rstd.ready", {31'd0, o_ready}, 32'd1);
        chk("rstd.last", {31'd0, o_last}, 32'd0);
        chk("rstd.data", {16'd0, o_data}, 32'd0);
        i_ready = 1'b0;

        // Reset mid-LOAD after 5 scores
        for (int i = 0; i < 5; i++) begin
            i_valid = 1'b1;
            i_data  = 16'h7FFF;
            @(negedge clk);
        end
        i_valid = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstl.valid", {31'd0, o_valid}, 32'd0);
        chk("rstl.ready", {31'd0, o_ready}, 32'd1);

        // Fresh descending row after both resets: outputs -i
        for (int i = 0; i < 16; i++) begin
            row[i]   = 16'd15 - 16'(i);
            exp_q[i] = 16'd0 - 16'(i);
        end
        load_row("post");
        drain_from("post", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/softmax_max_sub.md
SOFTMAX_MAX_SUB -- requirements
Module: softmax_max_sub

Interface
REQ-001 Parameter ROW_LEN, default 16; number of scores per softmax row; legal values 2..64.
REQ-002 Parameter DW, default 16; sample width. Format is signed Q2.13: 1 sign bit, 2 integer bits, 13 fraction bits.
REQ-003 I_CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 I_RST  input  1  reset, synchronous and active-high.
REQ-005 I_VALID  input  1  upstream score valid.
REQ-006 I_DATA  input  DW  upstream score, signed Q2.13.
REQ-007 O_READY  output  1  block can accept a score this cycle.
REQ-008 O_VALID  output  1  O_DATA holds a max-subtracted value for the exp stage.
REQ-009 O_DATA  output  DW  buffered score minus row maximum, signed Q2.13, always <= 0.
REQ-010 O_LAST  output  1  high together with O_VALID on the final element of a row.
REQ-011 I_READY  input  1  downstream (exp stage) accepts O_DATA this cycle.

Function
REQ-012 The block SHALL have two states, LOAD and DRAIN; the state after reset is LOAD.
REQ-013 In LOAD, O_READY SHALL be 1 and O_VALID SHALL be 0.
- Each cycle with I_VALID=1, the block SHALL store I_DATA into buffer[wr_idx] and increment wr_idx.
REQ-014 The running maximum SHALL use a signed compare and SHALL be updated only when the new score is strictly greater. The first accepted score of a row SHALL load the maximum unconditionally.
REQ-015 When the ROW_LEN-th score is accepted, the block SHALL enter DRAIN on the next edge. On that same edge, O_DATA SHALL be loaded with buffer[0] minus the final maximum, with the just-accepted score and its max contribution included.
- Latency: O_VALID rises exactly 1 cycle after the last input handshake.
REQ-016 In DRAIN, O_READY SHALL be 0 and O_VALID SHALL be 1.
- O_DATA and O_LAST SHALL hold stable while I_READY=0.
REQ-017 On each output handshake (O_VALID & I_READY), rd_idx SHALL increment and O_DATA SHALL load the next buffered element minus the maximum. Throughput is 1 element per cycle when I_READY is held high.
REQ-018 O_LAST SHALL be 1 exactly when rd_idx = ROW_LEN-1.
- On the handshake of that element, the block SHALL return to LOAD on the next edge, with wr_idx=0, rd_idx=0 and O_READY=1.
REQ-019 Subtraction SHALL be computed at DW+1 bits. Results below -4.0 SHALL saturate to 16'h8000; no wrap-around is permitted.
REQ-020 Scores presented while O_READY=0 SHALL be ignored. A row is never truncated: a row length is always exactly ROW_LEN.

Reset
REQ-021 When I_RST=1 at an edge, the block SHALL set:
- state=LOAD, wr_idx=0, rd_idx=0, maximum=16'h8000;
- O_VALID=0, O_LAST=0, O_DATA=0, O_READY=1 from the following cycle.
REQ-022 Reset asserted mid-LOAD or mid-DRAIN SHALL discard the partial row; no output SHALL be produced for it. Buffer contents need not be cleared.

Configuration
REQ-023 Macro SOFTMAX_ROWMAX_OUT_EN:
- When defined, the block SHALL add output O_ROW_MAX (DW bits), equal to the final row maximum, registered and valid throughout DRAIN. It lets the downstream normaliser undo the shift.
- When undefined, the port and its register SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-024 ROW_LEN=16, inputs 16'h0000..16'h000F, I_READY=1: O_DATA sequence 16'hFFF1..16'h0000; O_LAST only on the 16th output; O_VALID rises 1 cycle after the 16th input.
REQ-025 Row containing 16'h7FFF and 16'h8000, rest 0: the 16'h8000 element outputs 16'h8000 (saturated), the 16'h7FFF element outputs 0, zero elements output 16'h8001.
REQ-026 All-negative row, every element 16'hE000: all outputs 16'h0000 (tie keeps the maximum; result equals 0).
REQ-027 Backpressure: I_READY low for 5 cycles at rd_idx=3 keeps O_DATA and O_LAST constant and holds O_READY at 0. Toggling I_VALID in DRAIN produces no buffer change.
REQ-028 I_RST pulsed at rd_idx=7: next cycle O_VALID=0 and O_READY=1. A following full row drains correctly with no stale elements.
REQ-029 With SOFTMAX_ROWMAX_OUT_EN defined, the REQ-024 stimulus gives O_ROW_MAX=16'h000F throughout DRAIN.
